dadda_mult_arbiter: RTL

Round-robin arbiter and scheduler that shares one combinational 4x4 `dadda_multiplier` instance among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one requester per cycle and feeds the winner's operands through the multiplier. It captures the 8-bit product plus the requester ID in a result register, which drains through a valid/ready response port. The block sits between operand-producing clients and the shared multiplier datapath.

---
 rtl/dadda_pkg.sv | 8 +
 rtl/dadda_mult_arbiter_rr_arbiter.sv | 31 +++
 rtl/dadda_multiplier.sv | 15 +
 rtl/dadda_mult_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/dadda_pkg.sv
// Shared widths and types for the dadda_mult_arbiter slice.
package dadda_pkg;
    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    localparam int CNT_W  = 16;

    typedef logic [PROD_W-1:0] prod_t;
endpackage

// File: rtl/dadda_mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: priority starts just after `last` and wraps; `last` is lowest priority.
module rr_arbiter
    import dadda_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);
    logic        found;
    int unsigned idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
        if (found && enable) grant[grant_id] = 1'b1;
    end
endmodule

// File: rtl/dadda_multiplier.sv
// Combinational 4x4 unsigned multiplier: partial-product array summed in one column tree.
module dadda_multiplier
    import dadda_pkg::*;
(
    input  logic [OP_W-1:0] A,
    input  logic [OP_W-1:0] B,
    output prod_t           product
);
    always_comb begin
        product = '0;
        for (int unsigned j = 0; j < OP_W; j++) begin
            if (B[j]) product = product + (prod_t'(A) << j);
        end
    end
endmodule

// File: rtl/dadda_mult_arbiter.sv
// Shares one dadda_multiplier among NUM_REQ valid/ready requesters with a registered response.
// Optional per-requester grant counters: define DADDA_ARB_STATS_EN.
module dadda_mult_arbiter
    import dadda_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_a,
    input  logic [NUM_REQ*OP_W-1:0]   req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [PROD_W-1:0]         rsp_product,
    output logic [ID_W-1:0]           rsp_id
`ifdef DADDA_ARB_STATS_EN
    ,
    input  logic                      stat_clear,
    output logic [NUM_REQ*CNT_W-1:0]  grant_count
`endif
);
    logic               rsp_valid_q;
    prod_t              rsp_product_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [ID_W-1:0]    last_q;

    logic               slot_free;
    logic               accept;
    logic [ID_W-1:0]    grant_id;
    logic [OP_W-1:0]    a_sel;
    logic [OP_W-1:0]    b_sel;
    prod_t              product;

    assign slot_free = !rsp_valid_q || rsp_ready;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req      (req_valid),
        .last     (last_q),
        .enable   (slot_free),
        .grant    (req_ready),
        .grant_id (grant_id)
    );

    // Grant is a subset of req_valid, so any grant bit is an accept.
    assign accept = |req_ready;
    assign a_sel  = req_a[grant_id*OP_W +: OP_W];
    assign b_sel  = req_b[grant_id*OP_W +: OP_W];

    dadda_multiplier u_mul (
        .A       (a_sel),
        .B       (b_sel),
        .product (product)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_q   <= 1'b0;
            rsp_product_q <= '0;
            rsp_id_q      <= '0;
            last_q        <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            rsp_valid_q   <= 1'b1;
            rsp_product_q <= product;
            rsp_id_q      <= grant_id;
            last_q        <= grant_id;
        end else if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;
    assign rsp_id      = rsp_id_q;

`ifdef DADDA_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (stat_clear) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) grant_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif
endmodule
